// File: rtl/mastermind_pkg.sv
// mastermind_pkg
// Shared definitions for the Mastermind blocks:
//   state_t   - round controller states
//   RED..GRN  - LED colour codes used by led_driver / color_coder
//   cnt_width - width needed to hold a count of 0..n inclusive
package mastermind_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_EXACT,
        ST_PARTIAL,
        ST_REPORT,
        ST_DONE
    } state_t;

    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YLW = 2'b01;
    localparam logic [1:0] BLU = 2'b10;
    localparam logic [1:0] GRN = 2'b11;

    // Bits required to represent every value 0..n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/peg_match_unit.sv
// peg_match_unit
// Combinational search for the lowest-index code peg that is still unused
// and carries the given symbol.
//   code         - packed secret code, peg 0 in the MSBs
//   sym          - guess symbol being matched
//   used_code    - bit j set when code peg j is already consumed
//   found        - at least one candidate peg exists
//   match_onehot - one-hot mask of the lowest candidate peg (bit j = peg j)
module peg_match_unit #(
    parameter int PEGS  = 4,
    parameter int SYM_W = 4
) (
    input  logic [PEGS*SYM_W-1:0] code,
    input  logic [SYM_W-1:0]      sym,
    input  logic [PEGS-1:0]       used_code,
    output logic                  found,
    output logic [PEGS-1:0]       match_onehot
);

    logic [PEGS-1:0] cand;

    genvar gi;
    generate
        for (gi = 0; gi < PEGS; gi++) begin : g_cand
            assign cand[gi] = !used_code[gi] &&
                              (code[(PEGS-1-gi)*SYM_W +: SYM_W] == sym);
        end
    endgenerate

    assign found = |cand;
    // Isolate the lowest set bit: x & -x.
    assign match_onehot = cand & (~cand + PEGS'(1));

endmodule

// File: rtl/mastermind_round_ctrl.sv
// mastermind_round_ctrl
// Holds a secret code, accepts guesses over valid/ready, scores each guess
// iteratively (exact pass, then one partial-match step per peg), counts
// turns and flags win / loss.
//   clk, rst            - clock, synchronous active-high reset
//   code_valid, code_i  - load new secret (IDLE / DONE only)
//   guess_valid/_ready  - guess handshake, guess_i sampled on acceptance
//   score_valid         - one-cycle pulse with hits_o / blows_o
//   turn_o              - guesses scored in the current game
//   won_o, lost_o       - sticky game result; lock_o mirrors won_o
module mastermind_round_ctrl
    import mastermind_pkg::*;
#(
    parameter int  PEGS      = 4,
    parameter int  SYM_W     = 4,
    parameter int  MAX_TURNS = 10,
    localparam int CW        = cnt_width(PEGS),
    localparam int TW        = cnt_width(MAX_TURNS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  code_valid,
    input  logic [PEGS*SYM_W-1:0] code_i,
    input  logic                  guess_valid,
    output logic                  guess_ready,
    input  logic [PEGS*SYM_W-1:0] guess_i,
    output logic                  score_valid,
    output logic [CW-1:0]         hits_o,
    output logic [CW-1:0]         blows_o,
    output logic [TW-1:0]         turn_o,
    output logic                  won_o,
    output logic                  lost_o,
    output logic                  lock_o
);

    localparam int KW = $clog2(PEGS);
    localparam int DW = PEGS * SYM_W;

    state_t          state_reg;
    logic [DW-1:0]   code_reg;
    logic [DW-1:0]   guess_reg;
    logic [PEGS-1:0] used_code_reg;
    logic [PEGS-1:0] used_guess_reg;
    logic [CW-1:0]   hits_reg;
    logic [CW-1:0]   blows_reg;
    logic [KW-1:0]   k_reg;
    logic            score_valid_reg;
    logic [CW-1:0]   hits_out_reg;
    logic [CW-1:0]   blows_out_reg;
    logic [TW-1:0]   turn_reg;
    logic            won_reg;
    logic            lost_reg;

    logic [PEGS-1:0] hit_mask;
    logic [CW-1:0]   hit_count;
    logic [SYM_W-1:0] guess_sym;
    logic            match_found;
    logic [PEGS-1:0] match_onehot;
    logic [TW-1:0]   turn_next;

    genvar gi;
    generate
        for (gi = 0; gi < PEGS; gi++) begin : g_hit
            assign hit_mask[gi] = (code_reg[(PEGS-1-gi)*SYM_W +: SYM_W] ==
                                   guess_reg[(PEGS-1-gi)*SYM_W +: SYM_W]);
        end
    endgenerate

    always_comb begin
        hit_count = '0;
        for (int i = 0; i < PEGS; i++) begin
            hit_count = hit_count + CW'(hit_mask[i]);
        end
    end

    // Guess symbol for the current partial step (peg 0 sits in the MSBs).
    assign guess_sym = SYM_W'(guess_reg >> ((PEGS - 1 - int'(k_reg)) * SYM_W));
    assign turn_next = turn_reg + TW'(1);

    peg_match_unit #(
        .PEGS  (PEGS),
        .SYM_W (SYM_W)
    ) u_match (
        .code         (code_reg),
        .sym          (guess_sym),
        .used_code    (used_code_reg),
        .found        (match_found),
        .match_onehot (match_onehot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            code_reg        <= '0;
            guess_reg       <= '0;
            used_code_reg   <= '0;
            used_guess_reg  <= '0;
            hits_reg        <= '0;
            blows_reg       <= '0;
            k_reg           <= '0;
            score_valid_reg <= 1'b0;
            hits_out_reg    <= '0;
            blows_out_reg   <= '0;
            turn_reg        <= '0;
            won_reg         <= 1'b0;
            lost_reg        <= 1'b0;
        end else begin
            score_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    // A guess offered alongside code_valid is simply dropped.
                    if (code_valid) begin
                        code_reg  <= code_i;
                        turn_reg  <= '0;
                        won_reg   <= 1'b0;
                        lost_reg  <= 1'b0;
                        state_reg <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (guess_valid) begin
                        guess_reg <= guess_i;
                        state_reg <= ST_EXACT;
                    end
                end
                ST_EXACT: begin
                    // Exact hits consume their pegs on both sides up front.
                    used_code_reg  <= hit_mask;
                    used_guess_reg <= hit_mask;
                    hits_reg       <= hit_count;
                    blows_reg      <= '0;
                    k_reg          <= '0;
                    state_reg      <= ST_PARTIAL;
                end
                ST_PARTIAL: begin
                    if (!used_guess_reg[k_reg] && match_found) begin
                        used_code_reg <= used_code_reg | match_onehot;
                        blows_reg     <= blows_reg + CW'(1);
                    end
                    k_reg <= k_reg + KW'(1);
                    if (k_reg == KW'(PEGS - 1)) begin
                        state_reg <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    score_valid_reg <= 1'b1;
                    hits_out_reg    <= hits_reg;
                    blows_out_reg   <= blows_reg;
                    turn_reg        <= turn_next;
                    if (hits_reg == CW'(PEGS)) begin
                        won_reg   <= 1'b1;
                        state_reg <= ST_DONE;
                    end else if (turn_next == TW'(MAX_TURNS)) begin
                        lost_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        state_reg <= ST_READY;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign guess_ready = (state_reg == ST_READY);
    assign score_valid = score_valid_reg;
    assign hits_o      = hits_out_reg;
    assign blows_o     = blows_out_reg;
    assign turn_o      = turn_reg;
    assign won_o       = won_reg;
    assign lost_o      = lost_reg;
    assign lock_o      = won_reg;

endmodule

// File: tb/tb_mastermind_round_ctrl.sv
// tb_mastermind_round_ctrl
// Directed scenarios for the round controller, checked every cycle against
// a game-level reference model plus hand-computed literal expectations.
module tb_mastermind_round_ctrl;

    localparam int PEGS      = 4;
    localparam int SYM_W     = 4;
    localparam int MAX_TURNS = 10;
    localparam int DW        = PEGS * SYM_W;
    localparam int CW        = 3;
    localparam int TW        = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          code_valid = 1'b0;
    logic [DW-1:0] code_i = '0;
    logic          guess_valid = 1'b0;
    logic [DW-1:0] guess_i = '0;
    logic          guess_ready;
    logic          score_valid;
    logic [CW-1:0] hits_o;
    logic [CW-1:0] blows_o;
    logic [TW-1:0] turn_o;
    logic          won_o;
    logic          lost_o;
    logic          lock_o;

    always #5 clk = ~clk;

    mastermind_round_ctrl #(
        .PEGS      (PEGS),
        .SYM_W     (SYM_W),
        .MAX_TURNS (MAX_TURNS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .code_valid  (code_valid),
        .code_i      (code_i),
        .guess_valid (guess_valid),
        .guess_ready (guess_ready),
        .guess_i     (guess_i),
        .score_valid (score_valid),
        .hits_o      (hits_o),
        .blows_o     (blows_o),
        .turn_o      (turn_o),
        .won_o       (won_o),
        .lost_o      (lost_o),
        .lock_o      (lock_o)
    );

    int n_err = 0;
    int n_chk = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Mastermind score from symbol histograms: hits are positional matches,
    // total common symbols is sum of per-symbol minimum counts.
    function automatic void score(input logic [DW-1:0] c, input logic [DW-1:0] g,
                                  output int h, output int b);
        int cc[16];
        int gc[16];
        int tot;
        logic [3:0] cs;
        logic [3:0] gs;
        h = 0;
        tot = 0;
        for (int s = 0; s < 16; s++) begin
            cc[s] = 0;
            gc[s] = 0;
        end
        for (int i = 0; i < PEGS; i++) begin
            cs = 4'(c >> ((PEGS - 1 - i) * SYM_W));
            gs = 4'(g >> ((PEGS - 1 - i) * SYM_W));
            if (cs == gs) h++;
            cc[cs]++;
            gc[gs]++;
        end
        for (int s = 0; s < 16; s++) begin
            tot += (cc[s] < gc[s]) ? cc[s] : gc[s];
        end
        b = tot - h;
    endfunction

    // Game-level model: phase 0 idle, 1 ready, 2 scoring, 3 done.
    int            m_phase = 0;
    int            m_cnt = 0;
    int            m_hits = 0;
    int            m_blows = 0;
    int            m_turn = 0;
    bit            m_sv = 1'b0;
    bit            m_won = 1'b0;
    bit            m_lost = 1'b0;
    logic [DW-1:0] m_code = '0;
    logic [DW-1:0] m_guess = '0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_phase = 0; m_sv = 0; m_hits = 0; m_blows = 0;
                m_turn = 0; m_won = 0; m_lost = 0;
            end else begin
                m_sv = 0;
                case (m_phase)
                    0, 3: if (code_valid) begin
                        m_code = code_i; m_turn = 0; m_won = 0; m_lost = 0; m_phase = 1;
                    end
                    1: if (guess_valid) begin
                        m_guess = guess_i; m_cnt = PEGS + 2; m_phase = 2;
                    end
                    default: begin
                        m_cnt--;
                        if (m_cnt == 0) begin
                            score(m_code, m_guess, m_hits, m_blows);
                            m_sv = 1;
                            m_turn++;
                            if (m_hits == PEGS) begin
                                m_won = 1; m_phase = 3;
                            end else if (m_turn == MAX_TURNS) begin
                                m_lost = 1; m_phase = 3;
                            end else begin
                                m_phase = 1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("guess_ready", int'(guess_ready), (m_phase == 1) ? 1 : 0);
                chk("score_valid", int'(score_valid), int'(m_sv));
                chk("hits_o", int'(hits_o), m_hits);
                chk("blows_o", int'(blows_o), m_blows);
                chk("turn_o", int'(turn_o), m_turn);
                chk("won_o", int'(won_o), int'(m_won));
                chk("lost_o", int'(lost_o), int'(m_lost));
                chk("lock_o", int'(lock_o), int'(m_won));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input logic [DW-1:0] c, input bit with_guess);
        code_i = c;
        code_valid = 1'b1;
        guess_valid = with_guess;
        guess_i = 16'h5555;
        @(negedge clk);
        code_valid = 1'b0;
        guess_valid = 1'b0;
    endtask

    // Offer a guess, wait for acceptance and the score pulse, check literals.
    task automatic play(input logic [DW-1:0] g, input int eh, input int eb);
        int n;
        n = 0;
        guess_i = g;
        guess_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (m_phase == 1 && n < 20);
        if (n >= 20) chk("accept_timeout", 0, 1);
        guess_valid = 1'b0;
        guess_i = ~g;
        n = 0;
        while (!score_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, PEGS + 2);
        chk("lit_hits", int'(hits_o), eh);
        chk("lit_blows", int'(blows_o), eb);
        $display("guess %h -> hits=%0d blows=%0d turn=%0d", g, hits_o, blows_o, turn_o);
    endtask

    initial begin
        int h;
        int b;
        int last;
        int np;

        // Pin the reference model itself.
        score(16'h1234, 16'h1234, h, b); chk("model_a_h", h, 4); chk("model_a_b", b, 0);
        score(16'h1123, 16'h1111, h, b); chk("model_b_h", h, 2); chk("model_b_b", b, 0);
        score(16'h1122, 16'h2211, h, b); chk("model_c_h", h, 0); chk("model_c_b", b, 4);
        score(16'h1223, 16'h2222, h, b); chk("model_d_h", h, 2); chk("model_d_b", b, 0);

        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_turn", int'(turn_o), 0);
        chk("rst_ready", int'(guess_ready), 0);
        chk("rst_hits", int'(hits_o), 0);
        rst = 1'b0;

        // 1: winning guess
        load(16'h1234, 1'b0);
        play(16'h1234, 4, 0);
        chk("win_won", int'(won_o), 1);
        chk("win_lock", int'(lock_o), 1);
        @(negedge clk);
        chk("win_ready", int'(guess_ready), 0);

        // 2: duplicates; code_valid in READY must be ignored
        load(16'h1123, 1'b0);
        code_i = 16'h1111;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        play(16'h1111, 2, 0);

        // 3: pure blows and duplicate guess
        do_reset();
        load(16'h1122, 1'b0);
        play(16'h2211, 0, 4);
        do_reset();
        load(16'h1223, 1'b0);
        play(16'h2222, 2, 0);

        // 4: exhaust turns, then reload from DONE with a concurrent guess
        do_reset();
        load(16'h1234, 1'b0);
        for (int i = 1; i <= MAX_TURNS; i++) begin
            play(16'h0000, 0, 0);
            chk("turn_count", int'(turn_o), i);
        end
        chk("lost_set", int'(lost_o), 1);
        chk("lost_won", int'(won_o), 0);
        chk("lost_ready", int'(guess_ready), 0);
        load(16'h5555, 1'b1);
        chk("reload_turn", int'(turn_o), 0);
        chk("reload_lost", int'(lost_o), 0);
        chk("reload_ready", int'(guess_ready), 1);
        play(16'h5555, 4, 0);

        // 5: reset in the third partial step aborts scoring
        load(16'h1234, 1'b0);
        guess_i = 16'h1234;
        guess_valid = 1'b1;
        @(negedge clk);
        guess_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_sv", int'(score_valid), 0);
        chk("abort_hits", int'(hits_o), 0);
        chk("abort_turn", int'(turn_o), 0);
        chk("abort_won", int'(won_o), 0);
        guess_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("idle_no_sv", int'(score_valid), 0);
            chk("idle_no_ready", int'(guess_ready), 0);
        end
        guess_valid = 1'b0;
        $display("abort scenario done");

        // 6: guess_valid held high with a changing guess
        load(16'h1234, 1'b0);
        last = -1;
        np = 0;
        guess_valid = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            guess_i = {4'h0, 4'(i), 4'h0, 4'hF};
            @(negedge clk);
            if (score_valid) begin
                if (last >= 0) chk("spacing", i - last, PEGS + 3);
                $display("streamed pulse at cycle %0d hits=%0d blows=%0d", i, hits_o, blows_o);
                last = i;
                np++;
            end
        end
        guess_valid = 1'b0;
        chk("pulse_count", np, 5);
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mastermind_round_ctrl.md
# mastermind_round_ctrl

Parametrised, sequential successor to the four-peg combinational scorer. It holds a secret code of `PEGS` symbols of `SYM_W` bits and accepts guesses through a valid/ready handshake. Each guess is scored iteratively with correct duplicate handling, producing exact hits (right symbol, right place) and blows (right symbol, wrong place). The block also counts turns and declares win or loss. It sits between `guess_generator` and `color_coder`/`led_driver` in `mastermind_top`, and replaces `mastermind_comb`.

## Interface
- `PEGS`, default 4: number of pegs per code/guess; must be ≥2.
- `SYM_W`, default 4: bits per symbol.
- `MAX_TURNS`, default 10: guesses allowed per game; must be ≥1.
- Derived widths: `CW = $clog2(PEGS+1)`, `TW = $clog2(MAX_TURNS+1)`.

Ports:
- `clk` input 1: the single clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `code_valid` input 1: load `code_i` as the new secret. Honoured only in IDLE or DONE.
- `code_i` input PEGS*SYM_W: secret code; peg 0 is the MSBs.
- `guess_valid` input 1: a guess is offered.
- `guess_ready` output 1: the block can accept a guess.
- `guess_i` input PEGS*SYM_W: guess, same packing as `code_i`.
- `score_valid` output 1: one-cycle pulse; `hits_o`/`blows_o` are valid.
- `hits_o` output CW: exact matches for the last scored guess.
- `blows_o` output CW: symbol-only matches for the last scored guess.
- `turn_o` output TW: guesses scored so far this game.
- `won_o` output 1: game won; sticky until a new code is loaded or reset.
- `lost_o` output 1: turns exhausted without a win; sticky like `won_o`.
- `lock_o` output 1: equals `won_o`; drives the lock actuator.

## Operation
States: IDLE, READY, EXACT, PARTIAL, REPORT, DONE.

- **Reset:** state IDLE. All outputs are 0, including `hits_o`, `blows_o` and `turn_o`.
- **IDLE:** when `code_valid` is high, register the code, clear `turn_o`, go to READY.
- **READY:** `guess_ready`=1. When `guess_valid && guess_ready`, register the guess, go to EXACT. `code_valid` is ignored here.
- **EXACT (1 cycle):**
  - `hit_mask[i] = (code[i]==guess[i])`.
  - `hits` = popcount(`hit_mask`).
  - `used_code` and `used_guess` are initialised to `hit_mask`.
  - `blows` cleared; index k=0.
- **PARTIAL (exactly PEGS cycles, k = 0..PEGS-1):**
  - Act only if `used_guess[k]`=0.
  - Find the lowest j with `used_code[j]`=0 and `code[j]==guess[k]`.
  - If found, set `used_code[j]` and increment `blows`.
  - Advance k; when k=PEGS-1, go to REPORT.
  - This yields `blows = Σ_sym min(cnt_code, cnt_guess) − hits`.
- **REPORT (1 cycle):**
  - `score_valid`=1; `hits_o`/`blows_o` are updated and held until the next REPORT.
  - `turn_o` increments.
  - If hits==PEGS: set `won_o`, go to DONE.
  - Else if the new turn == MAX_TURNS: set `lost_o`, go to DONE.
  - Else go to READY.
- **DONE:** `guess_ready`=0 and outputs hold. `code_valid` loads a new code, clears `won_o`, `lost_o` and `turn_o`, and goes to READY. `hits_o`/`blows_o` keep their last values.

Boundary rules:
- `guess_valid` outside READY is ignored; there is no queueing.
- A guess change after acceptance has no effect, because the guess is registered.
- `rst` asserted during any state aborts scoring: no `score_valid` pulse, and everything returns to reset values on the next edge.
- `code_valid` together with `guess_valid` in IDLE/DONE: the code is loaded and the guess is ignored.
- `turn_o` never exceeds MAX_TURNS.
- `won_o` and `lost_o` are never both 1.

## Timing
- Guess accepted at rising edge E.
- `score_valid` is high for exactly the one cycle beginning at edge E+PEGS+2. For PEGS=4, that is 6 cycles after acceptance.
- `guess_ready` returns to 1 in the cycle after the REPORT cycle, unless the game is over.
- Minimum guess-to-guess spacing: PEGS+3 cycles.
- `won_o`, `lost_o` and `lock_o` rise in the cycle after REPORT and fall in the cycle after `code_valid` is accepted in DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- **`mastermind_pkg`:**
  - state enum;
  - LED colour constants RED/YLW/BLU/GRN (2'b00/01/10/11), shared with `led_driver`/`color_coder`;
  - width helper function for `CW`/`TW`.
- **One sub-module, `peg_match_unit`:** combinational logic, parametrised by PEGS/SYM_W.
  - Inputs: code, guess symbol k, `used_code`.
  - Outputs: found flag and one-hot j (lowest-index priority).
  - Instantiated once inside the PARTIAL datapath.

## Test plan
Code/guess values are written peg 0 first, hex symbols, PEGS=4, SYM_W=4, MAX_TURNS=10.
1. Code 1234, guess 1234 → `score_valid` exactly 6 cycles after acceptance; hits=4, blows=0; `won_o`=`lock_o`=1; `guess_ready`=0.
2. Code 1123, guess 1111 → hits=2, blows=0 (duplicates must not be counted as blows).
3. Code 1122, guess 2211 → hits=0, blows=4. Code 1223, guess 2222 → hits=2, blows=0.
4. Ten guesses of 0000 against code 1234 → `turn_o` counts 1..10; after the 10th REPORT `lost_o`=1 and `guess_ready`=0. Then `code_valid` with code 5555 → `turn_o`=0, `lost_o`=0, READY.
5. Assert `rst` in the 3rd PARTIAL cycle → no `score_valid` pulse; all outputs 0 next cycle; state IDLE, ignoring `guess_valid` until `code_valid`.
6. Hold `guess_valid` high continuously with changing `guess_i` → only values sampled while `guess_ready`=1 are scored; `score_valid` pulses are exactly PEGS+3 cycles apart.
